// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encodings, port indices, width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_ST_IDLE   = 2'd0,
        ARB_ST_ACCESS = 2'd1,
        ARB_ST_RESP   = 2'd2
    } arb_state_e;

    localparam int unsigned ARB_PORT_HOST  = 0;
    localparam int unsigned ARB_PORT_EXEC  = 1;
    localparam int unsigned ARB_PORT_FETCH = 2;

    function automatic int unsigned arb_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection: lock owner first, then fixed priority or, with
// ARB_ROUND_ROBIN_EN defined, a round-robin search starting at rr_ptr.
module arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = arb_idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic [IDX_W-1:0] lock_owner,
    input  logic             lock_en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
`endif

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        if (lock_en && valid[lock_owner]) begin
            grant_idx = lock_owner;
            grant_any = 1'b1;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            for (int k = 0; k < int'(NREQ); k++) begin
                int unsigned idx;
                idx = (int unsigned'(rr_ptr) + int unsigned'(k)) % NREQ;
                if (!grant_any && valid[idx]) begin
                    grant_idx = IDX_W'(idx);
                    grant_any = 1'b1;
                end
            end
`else
            // Descending scan so the lowest valid index is the last one written.
            for (int k = int'(NREQ) - 1; k >= 0; k--) begin
                if (valid[k]) begin
                    grant_idx = IDX_W'(k);
                    grant_any = 1'b1;
                end
            end
`endif
        end
        grant = grant_any ? (NREQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one access in flight, 2-cycle request-to-response latency,
// per-port lock with MAX_LOCK limit. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREQ     = 3,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);

    localparam int unsigned IDX_W = arb_idx_w(NREQ);
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e state_q, state_d;

    logic [IDX_W-1:0]  lat_idx_q;
    logic              lat_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [NREQ-1:0]   rsp_valid_q;

    logic              lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]  lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;

    logic              arb_cycle, lock_en, lock_hit, accept;
    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic [IDX_W-1:0]  rr_ptr;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    assign arb_cycle = (state_q == ARB_ST_IDLE) || (state_q == ARB_ST_RESP);
    assign lock_en   = lock_valid_q && (lock_cnt_q < CNT_W'(MAX_LOCK));
    // Owner wins through the lock this cycle; such grants do not advance rr_ptr.
    assign lock_hit  = lock_en && req_valid[lock_owner_q];
    assign accept    = arb_cycle && grant_any;

    arb_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb_pick (
        .valid      (req_valid),
        .rr_ptr     (rr_ptr),
        .lock_owner (lock_owner_q),
        .lock_en    (lock_en),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ARB_ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_ST_IDLE:   state_d = accept ? ARB_ST_ACCESS : ARB_ST_IDLE;
            ARB_ST_ACCESS: state_d = ARB_ST_RESP;
            ARB_ST_RESP:   state_d = accept ? ARB_ST_ACCESS : ARB_ST_IDLE;
            default:       state_d = ARB_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != ARB_ST_IDLE);
        req_ready = (accept && reset) ? grant : '0;
        rsp_rdata = ((|rsp_valid_q) && !lat_we_q) ? mem_rdata : '0;
    end

    assign rsp_valid = rsp_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_idx_q   <= '0;
            lat_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rsp_valid_q <= '0;
        end else begin
            mem_we_q    <= 1'b0;
            rsp_valid_q <= (state_q == ARB_ST_ACCESS) ? (NREQ'(1) << lat_idx_q) : '0;
            if (accept) begin
                lat_idx_q   <= grant_idx;
                lat_we_q    <= req_we[grant_idx];
                mem_addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                mem_wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
                mem_we_q    <= req_we[grant_idx];
            end
        end
    end

    // Any arbitration that does not grant a locked request releases the lock.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        if (arb_cycle) begin
            if (accept && req_lock[grant_idx]) begin
                lock_valid_d = 1'b1;
                lock_owner_d = grant_idx;
                if (!lock_hit) begin
                    lock_cnt_d = CNT_W'(1);
                end else if (lock_cnt_q != CNT_W'(MAX_LOCK)) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end else begin
                lock_valid_d = 1'b0;
                lock_owner_d = '0;
                lock_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && !lock_hit) begin
            rr_ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, lock/reset sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int NREQ     = 3;
    localparam int AW       = 16;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ-1:0]      req_lock = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata = '0;
    logic                 busy;

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NREQ     (NREQ),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Sync-read memory with 1-cycle latency.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
    endtask

    task automatic set_req(input int p, input logic we, input logic lock,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p]           = 1'b1;
        req_we[p]              = we;
        req_lock[p]            = lock;
        req_addr[p*AW +: AW]   = a;
        req_wdata[p*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "/req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "/rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "/mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "/mem_we"},    64'(mem_we),    64'd0);
        check({tag, "/mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "/busy"},      64'(busy),      64'd0);
    endtask

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // One isolated access from an idle arbiter; checks every stage of the 2-cycle latency.
    task automatic single_access(input vec_t v, input string tag);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << v.port;
        @(posedge clk); #1;
        set_req(v.port, v.we, 1'b0, v.addr, v.wdata);
        @(negedge clk);
        check({tag, "/ready"}, 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check({tag, "/mem_addr"}, 64'(mem_addr), 64'(v.addr));
        check({tag, "/mem_we"}, 64'(mem_we), 64'(v.we));
        if (v.we) check({tag, "/mem_wdata"}, 64'(mem_wdata), 64'(v.wdata));
        check({tag, "/no_early_rsp"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check({tag, "/rsp_valid"}, 64'(rsp_valid), 64'(oh));
        check({tag, "/rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        check({tag, "/mem_we_low"}, 64'(mem_we), 64'd0);
    endtask

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    initial begin
        rsp_t            rsp_q [$];
        int              owner, cnt, rr, last_gnt, w;
        logic            last_we, via_lock;
        logic [AW-1:0]   last_addr, a;
        logic [NREQ-1:0] exp_ready, exp_rv;
        logic [DW-1:0]   exp_rd;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 32'hD000_0001;

        vecs[0] = '{2, 1'b0, 16'h0010, 32'h0,          32'hD000_0001};
        vecs[1] = '{1, 1'b1, 16'h0020, 32'h1234_5678,  32'h0};
        vecs[2] = '{1, 1'b0, 16'h0020, 32'h0,          32'h1234_5678};
        vecs[3] = '{0, 1'b1, 16'h0030, 32'hCAFE_F00D,  32'h0};
        vecs[4] = '{2, 1'b0, 16'h0030, 32'h0,          32'hCAFE_F00D};
        vecs[5] = '{0, 1'b0, 16'h0010, 32'h0,          32'hD000_0001};

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 6; i++) single_access(vecs[i], $sformatf("vec%0d", i));

        // All ports requesting continuously.
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 16'h0040, '0);
        set_req(1, 1'b0, 1'b0, 16'h0041, '0);
        set_req(2, 1'b0, 1'b0, 16'h0042, '0);
        for (int k = 0; k < 12; k++) begin
            logic [NREQ-1:0] exp_g;
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = NREQ'(1) << ((k / 2) % NREQ);
`else
            exp_g = 3'b001;
`endif
            if (k % 2 == 0) check($sformatf("contend/ready%0d", k), 64'(req_ready), 64'(exp_g));
            else            check($sformatf("contend/gap%0d", k), 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(negedge clk);

        // Lock held by port2 against a continuously requesting port0, up to MAX_LOCK grants.
        do_reset();
        @(posedge clk); #1;
        set_req(2, 1'b0, 1'b1, 16'h0050, '0);
        @(negedge clk);
        check("lock/first", 64'(req_ready), 64'(3'b100));
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 16'h0051, '0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("lock/busy%0d", c), 64'(busy), 64'd1);
            if (c % 2 == 0) begin
                check($sformatf("lock/ready%0d", c), 64'(req_ready),
                      (c < 8) ? 64'(3'b100) : 64'(3'b001));
                check($sformatf("lock/rsp%0d", c), 64'(rsp_valid), 64'(3'b100));
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(negedge clk);

        // Lock owner drops valid for one arbitration: lock released.
        do_reset();
        @(posedge clk); #1;
        set_req(2, 1'b0, 1'b1, 16'h0060, '0);
        @(negedge clk);
        check("drop/first", 64'(req_ready), 64'(3'b100));
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 16'h0061, '0);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("drop/ready", 64'(req_ready), 64'(3'b010));
        check("drop/rsp2", 64'(rsp_valid), 64'(3'b100));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("drop/rsp1", 64'(rsp_valid), 64'(3'b010));
        check("drop/idle_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);

        // Reset asserted during ACCESS.
        do_reset();
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 16'h0070, 32'hBAD0_BAD0);
        @(negedge clk);
        check("rst/ready", 64'(req_ready), 64'(3'b010));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("rst_access");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst/no_rsp%0d", k), 64'(rsp_valid), 64'd0);
        end
        idle_inputs();
        reset = 1'b1;
        single_access(vecs[0], "after_rst");

        // Randomized traffic against the reference model.
        do_reset();
        owner    = -1;
        cnt      = 0;
        rr       = 0;
        last_gnt = -10;
        last_we  = 1'b0;
        last_addr = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < NREQ; p++) begin
                req_valid[p] = ($urandom_range(0, 99) < 60);
                req_we[p]    = 1'($urandom_range(0, 1));
                req_lock[p]  = ($urandom_range(0, 99) < 50);
                req_addr[p*AW +: AW]  = 16'h0080 + 16'($urandom_range(0, 7));
                req_wdata[p*DW +: DW] = $urandom;
            end
            exp_ready = '0;
            // An access occupies the cycle after its grant; every other cycle arbitrates.
            if (c != last_gnt + 1) begin
                via_lock = (owner >= 0) && req_valid[owner] && (cnt < MAX_LOCK);
                w = -1;
                if (via_lock) w = owner;
                else begin
`ifdef ARB_ROUND_ROBIN_EN
                    for (int k = 0; k < NREQ; k++)
                        if (w < 0 && req_valid[(rr + k) % NREQ]) w = (rr + k) % NREQ;
`else
                    for (int p = 0; p < NREQ; p++)
                        if (w < 0 && req_valid[p]) w = p;
`endif
                end
                if (w >= 0) begin
                    a = req_addr[w*AW +: AW];
                    exp_ready = NREQ'(1) << w;
                    last_gnt  = c;
                    last_we   = req_we[w];
                    last_addr = a;
                    rsp_q.push_back('{c + 2, w, req_we[w] ? 32'h0 : ref_mem[a[7:0]]});
                    if (req_we[w]) ref_mem[a[7:0]] = req_wdata[w*DW +: DW];
                    if (req_lock[w]) begin
                        cnt   = via_lock ? ((cnt < MAX_LOCK) ? cnt + 1 : cnt) : 1;
                        owner = w;
                    end else begin
                        owner = -1;
                        cnt   = 0;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    if (!via_lock) rr = (w + 1) % NREQ;
`endif
                end else begin
                    owner = -1;
                    cnt   = 0;
                end
            end
            @(negedge clk);
            exp_rv = '0;
            exp_rd = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due == c) begin
                exp_rv = NREQ'(1) << rsp_q[0].port;
                exp_rd = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end
            check($sformatf("rand%0d/ready", c), 64'(req_ready), 64'(exp_ready));
            check($sformatf("rand%0d/rsp_valid", c), 64'(rsp_valid), 64'(exp_rv));
            check($sformatf("rand%0d/rsp_rdata", c), 64'(rsp_rdata), 64'(exp_rd));
            check($sformatf("rand%0d/mem_we", c), 64'(mem_we),
                  64'((c == last_gnt + 1) && last_we));
            check($sformatf("rand%0d/busy", c), 64'(busy),
                  64'((c == last_gnt + 1) || (exp_rv != '0)));
            if (c == last_gnt + 1)
                check($sformatf("rand%0d/mem_addr", c), 64'(mem_addr), 64'(last_addr));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
